// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide engine producing {hi, lo} for the HI/LO file.
// Optional macro MULDIV_FAST_MULT_EN: single-cycle MULT/MULTU through a synthesised multiplier.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 state_q;
  logic [1:0]             op_q;
  logic [WIDTH-1:0]       num1_q;
  logic [WIDTH-1:0]       a_q;
  logic [WIDTH-1:0]       b_q;
  logic [2*WIDTH-1:0]     acc_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   neg_res_q;
  logic                   neg_rem_q;
  logic                   dz_q;
  logic                   busy_q;
  logic                   done_q;
  logic [WIDTH-1:0]       hi_q;
  logic [WIDTH-1:0]       lo_q;
  logic                   div_zero_q;

  logic                   signed_s;
  logic                   n1_neg_s;
  logic                   n2_neg_s;
  logic [WIDTH-1:0]       mag1_s;
  logic [WIDTH-1:0]       mag2_s;
  logic                   fast_s;
  logic [2*WIDTH-1:0]     fast_prod_s;
  logic [WIDTH:0]         mul_sum_s;
  logic [2*WIDTH:0]       div_sh_s;
  logic [WIDTH:0]         div_diff_s;
  logic [2*WIDTH-1:0]     acc_d;
  logic [2*WIDTH-1:0]     mul_res_s;
  logic [WIDTH-1:0]       fix_hi_d;
  logic [WIDTH-1:0]       fix_lo_d;

  // Operand magnitudes and optional single-cycle product for the incoming request
  always_comb begin
    signed_s = ~op[0];
    n1_neg_s = signed_s & num1[WIDTH-1];
    n2_neg_s = signed_s & num2[WIDTH-1];
    mag1_s   = n1_neg_s ? (~num1 + {{(WIDTH-1){1'b0}}, 1'b1}) : num1;
    mag2_s   = n2_neg_s ? (~num2 + {{(WIDTH-1){1'b0}}, 1'b1}) : num2;
`ifdef MULDIV_FAST_MULT_EN
    fast_s      = ~op[1];
    fast_prod_s = {{WIDTH{n1_neg_s}}, num1} * {{WIDTH{n2_neg_s}}, num2};
`else
    fast_s      = 1'b0;
    fast_prod_s = '0;
`endif
  end

  // One radix-2 step: shift-add multiply or restoring shift-subtract divide
  always_comb begin
    if (acc_q[0]) begin
      mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
    end else begin
      mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    end
    div_sh_s   = {acc_q, 1'b0};
    div_diff_s = div_sh_s[2*WIDTH:WIDTH] - {1'b0, b_q};
    if (!op_q[1]) begin
      acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
    end else if (div_diff_s[WIDTH]) begin
      acc_d = div_sh_s[2*WIDTH-1:0];
    end else begin
      acc_d = {div_diff_s[WIDTH-1:0], div_sh_s[WIDTH-1:1], 1'b1};
    end
  end

  // Sign correction applied during FIX; divide-by-zero returns all ones and the raw dividend
  always_comb begin
    mul_res_s = neg_res_q ? (~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;
    if (!op_q[1]) begin
      fix_hi_d = mul_res_s[2*WIDTH-1:WIDTH];
      fix_lo_d = mul_res_s[WIDTH-1:0];
    end else if (dz_q) begin
      fix_hi_d = num1_q;
      fix_lo_d = '1;
    end else begin
      fix_lo_d = neg_res_q ? (~acc_q[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1})
                           : acc_q[WIDTH-1:0];
      fix_hi_d = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1})
                           : acc_q[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 2'd0;
      num1_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start && !cancel && fast_s) begin
            hi_q       <= fast_prod_s[2*WIDTH-1:WIDTH];
            lo_q       <= fast_prod_s[WIDTH-1:0];
            div_zero_q <= 1'b0;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_DONE;
          end else if (start && !cancel) begin
            op_q      <= op;
            num1_q    <= num1;
            a_q       <= mag1_s;
            b_q       <= mag2_s;
            acc_q     <= {{WIDTH{1'b0}}, (op[1] ? mag1_s : mag2_s)};
            cnt_q     <= CNT_W'(WIDTH - 1);
            neg_res_q <= n1_neg_s ^ n2_neg_s;
            neg_rem_q <= n1_neg_s;
            dz_q      <= op[1] & (num2 == '0);
            busy_q    <= 1'b1;
            state_q   <= S_BUSY;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (cancel) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == '0) begin
              state_q <= S_FIX;
            end else begin
              state_q <= S_BUSY;
            end
          end
        end
        S_FIX: begin
          busy_q <= 1'b0;
          if (cancel) begin
            state_q <= S_IDLE;
          end else begin
            hi_q       <= fix_hi_d;
            lo_q       <= fix_lo_d;
            div_zero_q <= dz_q;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule
